reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Parametrised power-on/recovery reset generator; successor to the single-output fixed-delay reset stretcher.
- Holds NUM_STAGES reset domains in reset until the clock source reports lock and a filter confirms it is stable.
- After an initial delay, releases the domains one at a time, lowest index first, with a programmable gap between releases.
- Re-sequences from scratch on lock loss or on a software reset request. Sits at top level between the PLL/board reset and all downstream logic.

Parameters:
- NUM_STAGES, 3, number of sequenced reset outputs (>=1).
- LOCK_CYCLES, 16, consecutive edges iLOCK must be high before sequencing starts (>=1).
- INIT_DELAY, 1048576, edges from lock-confirmed to release of stage 0 (>=1).
- STAGE_DELAY, 1024, edges between release of stage k and stage k+1 (>=1).
- CNT_W, derived = $clog2(max(LOCK_CYCLES, INIT_DELAY, STAGE_DELAY)+1), internal counter width; not overridden.

Ports:
- iCLK  in  1  system clock; all logic on posedge.
- iRST  in  1  synchronous active-high reset.
- iLOCK  in  1  clock-source locked, synchronous to iCLK.
- iSOFT_RST  in  1  software re-sequence request, level-sensitive.
- oRST  out  NUM_STAGES  per-domain reset, active-high, registered.
- oSTAGE  out  $clog2(NUM_STAGES+1)  number of stages currently released (0..NUM_STAGES).
- oDONE  out  1  high when all stages are released.

Behaviour:
- Reset (iRST=1 at an edge): state=HOLD, cnt=0, oRST=all ones, oSTAGE=0, oDONE=0. iRST has top priority over all other inputs.
- Abort: if iRST=0 and (iLOCK=0 or iSOFT_RST=1) at an edge, the next state is HOLD, cnt=0, oRST=all ones, oSTAGE=0, oDONE=0, from any state.
  - Applies mid-sequence and in RUN.
  - Abort beats any release scheduled on the same edge.
- While iSOFT_RST stays high, the block remains in HOLD with cnt held at 0.
- State HOLD:
  - Each edge with iLOCK=1 and iSOFT_RST=0 increments cnt.
  - When cnt==LOCK_CYCLES-1 on such an edge, go to INIT with cnt=0.
  - Any edge with iLOCK=0 clears cnt.
- State INIT: cnt increments each edge. When cnt==INIT_DELAY-1: clear oRST[0], set oSTAGE=1, cnt=0.
  - If NUM_STAGES==1, go to RUN and set oDONE=1 on the same edge.
  - Otherwise go to STEP.
- State STEP: cnt increments each edge. When cnt==STAGE_DELAY-1: clear oRST[oSTAGE], increment oSTAGE, cnt=0.
  - If the new oSTAGE==NUM_STAGES, go to RUN and set oDONE=1 on the same edge.
- State RUN: outputs static, oRST=all zeros, oDONE=1, cnt frozen. Leaves only via reset or abort.
- Timing: count edges from the first edge with iRST=0, iLOCK=1, iSOFT_RST=0 as edge 1, with lock stable throughout.
  - oRST[0] falls at edge LOCK_CYCLES+INIT_DELAY.
  - oRST[k] falls at edge LOCK_CYCLES+INIT_DELAY+k*STAGE_DELAY.
  - oDONE rises on the same edge as oRST[NUM_STAGES-1] falls.
- Invariants:
  - oRST is thermometer-coded: oRST[j]=0 implies oRST[i]=0 for all i<j.
  - oSTAGE equals the count of zero bits in oRST.
  - Counters never wrap: each is bounded by its terminal compare, and CNT_W covers the largest delay.
- No combinational path from any input to any output.

Test Plan (NUM_STAGES=3, LOCK_CYCLES=4, INIT_DELAY=8, STAGE_DELAY=5 unless noted):
- Power-up: iRST=1 for 3 edges, then iRST=0 with iLOCK=1 held -> oRST=3'b111 until edge 12. Then 3'b110 at edge 12, 3'b100 at edge 17, 3'b000 and oDONE=1 at edge 22. oSTAGE steps 0,1,2,3 on those edges.
- Lock filter: iLOCK pulses high for 3 edges, low 1 edge, then high steadily -> the count restarts. oRST[0] falls 12 edges after the final rising of iLOCK.
- Mid-sequence abort: iLOCK drops at edge 18 (oRST=3'b100) -> at edge 18 oRST=3'b111, oSTAGE=0, oDONE=0. After iLOCK returns, the full 12/17/22 sequence repeats relative to the restart.
- Soft reset in RUN: iSOFT_RST=1 for 5 edges after oDONE=1 -> oRST=3'b111 for the whole pulse. Resequencing starts on the first edge with iSOFT_RST=0, and oDONE returns 22 edges later.
- Sync reset priority: iRST=1 on the same edge oRST[1] would release (edge 17) -> oRST=3'b111, state HOLD. No release occurs.
- NUM_STAGES=1, LOCK_CYCLES=1, INIT_DELAY=1 -> oRST[0]=0 and oDONE=1 together at edge 2; oSTAGE=1.

Source files
------------

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - lock-filtered multi-domain reset sequencer
// Releases NUM_STAGES reset domains one by one once the clock source is stable.
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int INIT_DELAY  = 1048576,
    parameter int STAGE_DELAY = 1024
) (
    input  logic                            iCLK,
    input  logic                            iRST,
    input  logic                            iLOCK,
    input  logic                            iSOFT_RST,
    output logic [NUM_STAGES-1:0]           oRST,
    output logic [$clog2(NUM_STAGES+1)-1:0] oSTAGE,
    output logic                            oDONE
);
    localparam int MAX_LI    = (LOCK_CYCLES > INIT_DELAY) ? LOCK_CYCLES : INIT_DELAY;
    localparam int MAX_DELAY = (MAX_LI > STAGE_DELAY) ? MAX_LI : STAGE_DELAY;
    localparam int CNT_W     = $clog2(MAX_DELAY + 1);
    localparam int STW       = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_DELAY - 1);
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [STW-1:0]   STAGE_ONE  = STW'(1);
    localparam logic [STW-1:0]   STAGE_FULL = STW'(NUM_STAGES);

    typedef enum logic [1:0] {HOLD, INIT, STEP, RUN} stateT;

    stateT                 state, stateNext;
    logic [CNT_W-1:0]      cnt, cntNext;
    logic [NUM_STAGES-1:0] rstReg, rstNext;
    logic [STW-1:0]        stageReg, stageNext;
    logic                  doneReg, doneNext;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= HOLD;
            cnt      <= '0;
            rstReg   <= '1;
            stageReg <= '0;
            doneReg  <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            rstReg   <= rstNext;
            stageReg <= stageNext;
            doneReg  <= doneNext;
        end
    end

    // Releases shift a zero in from the bottom, keeping oRST thermometer-coded.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        rstNext   = rstReg;
        stageNext = stageReg;
        doneNext  = doneReg;
        if (!iLOCK || iSOFT_RST) begin
            stateNext = HOLD;
            cntNext   = '0;
            rstNext   = '1;
            stageNext = '0;
            doneNext  = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == LOCK_LAST) begin
                        stateNext = INIT;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt + CNT_ONE;
                    end
                end
                INIT: begin
                    if (cnt == INIT_LAST) begin
                        cntNext   = '0;
                        rstNext   = rstReg << 1;
                        stageNext = stageReg + STAGE_ONE;
                        if (NUM_STAGES == 1) begin
                            stateNext = RUN;
                            doneNext  = 1'b1;
                        end else begin
                            stateNext = STEP;
                        end
                    end else begin
                        cntNext = cnt + CNT_ONE;
                    end
                end
                STEP: begin
                    if (cnt == STEP_LAST) begin
                        cntNext   = '0;
                        rstNext   = rstReg << 1;
                        stageNext = stageReg + STAGE_ONE;
                        if (stageReg + STAGE_ONE == STAGE_FULL) begin
                            stateNext = RUN;
                            doneNext  = 1'b1;
                        end
                    end else begin
                        cntNext = cnt + CNT_ONE;
                    end
                end
                RUN: begin
                    stateNext = RUN;
                end
                default: begin
                    stateNext = HOLD;
                    cntNext   = '0;
                    rstNext   = '1;
                    stageNext = '0;
                    doneNext  = 1'b0;
                end
            endcase
        end
    end

    assign oRST   = rstReg;
    assign oSTAGE = stageReg;
    assign oDONE  = doneReg;

endmodule
